// File: rtl/bus_cycle_decoder_pkg.sv
// Shared types and default address windows for the 6809 bus cycle decoder.
package bus_cycle_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SRAM,
    ROM,
    IO
  } dec_t;

  localparam logic [15:0] DEF_SRAM_BASE = 16'h0000;
  localparam logic [15:0] DEF_SRAM_TOP  = 16'h7FFF;
  localparam logic [15:0] DEF_IO_BASE   = 16'hA000;
  localparam logic [15:0] DEF_IO_TOP    = 16'hA0FF;
  localparam logic [15:0] DEF_ROM_BASE  = 16'hC000;
  localparam logic [15:0] DEF_ROM_TOP   = 16'hFFFF;

  // Overlapping windows resolve IO first, then ROM, then SRAM.
  function automatic dec_t decode_addr(
    input logic [15:0] addr,
    input logic [15:0] sram_base,
    input logic [15:0] sram_top,
    input logic [15:0] io_base,
    input logic [15:0] io_top,
    input logic [15:0] rom_base,
    input logic [15:0] rom_top
  );
    if (addr >= io_base && addr <= io_top) return IO;
    if (addr >= rom_base && addr <= rom_top) return ROM;
    if (addr >= sram_base && addr <= sram_top) return SRAM;
    return NONE;
  endfunction

endpackage

// File: rtl/bus_cycle_decoder_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, with registered-history
// rise/fall pulses one i_clk wide.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= '0;
      prev    <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
      prev    <= sync_sr[SYNC_STAGES-1];
    end
  end

  assign rise = sync_sr[SYNC_STAGES-1] & ~prev;
  assign fall = ~sync_sr[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/bus_cycle_decoder.sv
// 6809 bus cycle decoder: synchronises E/Q, latches address and R/W at Q rise,
// drives one registered chip select per cycle with wait states and timeout.
module bus_cycle_decoder
  import bus_cycle_decoder_pkg::*;
#(
  parameter logic [15:0] SRAM_BASE      = DEF_SRAM_BASE,
  parameter logic [15:0] SRAM_TOP       = DEF_SRAM_TOP,
  parameter logic [15:0] IO_BASE        = DEF_IO_BASE,
  parameter logic [15:0] IO_TOP         = DEF_IO_TOP,
  parameter logic [15:0] ROM_BASE       = DEF_ROM_BASE,
  parameter logic [15:0] ROM_TOP        = DEF_ROM_TOP,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned WAIT_CYCLES    = 0,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_E,
  input  logic        i_Q,
  input  logic [15:0] i_addr,
  input  logic        i_RW,
  output logic        o_sram_ce,
  output logic        o_rom_ce,
  output logic        o_io_ce,
  output logic        o_rw,
  output logic [15:0] o_addr,
  output logic        o_MRDY,
  output logic        o_bus_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic e_rise, e_fall, q_rise, q_fall;
  logic unused_edges;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_E),
    .rise (e_rise),
    .fall (e_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_Q),
    .rise (q_rise),
    .fall (q_fall)
  );

  assign unused_edges = &{1'b0, e_rise, q_fall};

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          sram_q, sram_d;
  logic          rom_q, rom_d;
  logic          io_q, io_d;
  logic [15:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic          mrdy_q, mrdy_d;
  logic          err_q, err_d;
  logic          start;
  dec_t          dec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      hold_q  <= '0;
      wait_q  <= '0;
      sram_q  <= 1'b0;
      rom_q   <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      mrdy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      sram_q  <= sram_d;
      rom_q   <= rom_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      mrdy_q  <= mrdy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    sram_d  = sram_q;
    rom_d   = rom_q;
    io_d    = io_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    mrdy_d  = mrdy_q;
    err_d   = 1'b0;
    start   = 1'b0;
    dec     = decode_addr(i_addr, SRAM_BASE, SRAM_TOP, IO_BASE, IO_TOP, ROM_BASE, ROM_TOP);

    // Wait-state countdown is independent of the FSM; MRDY releases as it expires.
    if (wait_q != '0) begin
      wait_d = wait_q - WW'(1);
      if (wait_q == WW'(1)) mrdy_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (q_rise) start = 1'b1;
      end
      ACTIVE: begin
        if (e_fall) begin
          state_d = HOLD;
          hold_d  = HW'(HOLD_CYCLES);
        end else if (tmo_q <= TW'(1)) begin
          state_d = IDLE;
          sram_d  = 1'b0;
          rom_d   = 1'b0;
          io_d    = 1'b0;
          mrdy_d  = 1'b1;
          wait_d  = '0;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      HOLD: begin
        if (q_rise) begin
          start = 1'b1;
        end else if (hold_q <= HW'(1)) begin
          state_d = IDLE;
          sram_d  = 1'b0;
          rom_d   = 1'b0;
          io_d    = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A Q rise during HOLD restarts here, so the new select overwrites the old one in one edge.
    if (start) begin
      state_d = ACTIVE;
      addr_d  = i_addr;
      rw_d    = i_RW;
      sram_d  = (dec == SRAM);
      rom_d   = (dec == ROM);
      io_d    = (dec == IO);
      tmo_d   = TW'(TIMEOUT_CYCLES);
      hold_d  = '0;
      if (dec == SRAM && WAIT_CYCLES != 0) begin
        mrdy_d = 1'b0;
        wait_d = WW'(WAIT_CYCLES);
      end else begin
        mrdy_d = 1'b1;
        wait_d = '0;
      end
    end
  end

  assign o_sram_ce = sram_q;
  assign o_rom_ce  = rom_q;
  assign o_io_ce   = io_q;
  assign o_rw      = rw_q;
  assign o_addr    = addr_q;
  assign o_MRDY    = mrdy_q;
  assign o_bus_err = err_q;

endmodule
